// File: rtl/exec_stage.sv
// MIPS execute stage: ALU-control decode, DATA_W-bit ALU and the EX/MEM pipeline register.
// Optional EXEC_SHIFT_EN adds SLL/SRL (funct 000000/000010) using x_shamt.
module exec_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              pc_rst,
  input  logic [1:0]        x_aluOp,
  input  logic [5:0]        x_funct,
  input  logic [4:0]        x_shamt,
  input  logic [DATA_W-1:0] x_aluIn0,
  input  logic [DATA_W-1:0] x_aluIn1,
  input  logic [DATA_W-1:0] x_writeData,
  input  logic [4:0]        x_writeReg,
  input  logic [1:0]        x_WB,
  input  logic [2:0]        x_M,
  output logic [3:0]        x_operation,
  output logic [DATA_W-1:0] x_aluResult,
  output logic              x_zero,
  output logic [DATA_W-1:0] m_aluResult,
  output logic [DATA_W-1:0] m_writeData,
  output logic [4:0]        m_writeReg,
  output logic [1:0]        m_WB,
  output logic [2:0]        m_M
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  always_comb begin
    x_operation = OP_ADD;
    case (x_aluOp)
      2'b01: x_operation = OP_SUB;
      2'b10: begin
        case (x_funct)
          6'b100000: x_operation = OP_ADD;
          6'b100010: x_operation = OP_SUB;
          6'b100100: x_operation = OP_AND;
          6'b100101: x_operation = OP_OR;
          6'b100111: x_operation = OP_NOR;
          6'b101010: x_operation = OP_SLT;
`ifdef EXEC_SHIFT_EN
          6'b000000: x_operation = OP_SLL;
          6'b000010: x_operation = OP_SRL;
`endif
          default:   x_operation = OP_ADD;
        endcase
      end
      default: x_operation = OP_ADD;
    endcase
  end

`ifndef EXEC_SHIFT_EN
  // shamt only feeds the shifter; keep it visibly consumed when shifts are absent
  logic unused_shamt;
  assign unused_shamt = ^x_shamt;
`endif

  always_comb begin
    x_aluResult = '0;
    case (x_operation)
      OP_AND: x_aluResult = x_aluIn0 & x_aluIn1;
      OP_OR:  x_aluResult = x_aluIn0 | x_aluIn1;
      OP_ADD: x_aluResult = x_aluIn0 + x_aluIn1;
      OP_SUB: x_aluResult = x_aluIn0 - x_aluIn1;
      OP_NOR: x_aluResult = ~(x_aluIn0 | x_aluIn1);
      OP_SLT: x_aluResult = {{(DATA_W-1){1'b0}}, ($signed(x_aluIn0) < $signed(x_aluIn1))};
`ifdef EXEC_SHIFT_EN
      OP_SLL: x_aluResult = x_aluIn1 << x_shamt;
      OP_SRL: x_aluResult = x_aluIn1 >> x_shamt;
`endif
      default: x_aluResult = '0;
    endcase
  end

  assign x_zero = (x_aluResult == '0);

  // EX/MEM register: no enable or flush; bubbles arrive as zeroed control
  always_ff @(posedge clk or negedge pc_rst) begin
    if (!pc_rst) begin
      m_aluResult <= '0;
      m_writeData <= '0;
      m_writeReg  <= '0;
      m_WB        <= '0;
      m_M         <= '0;
    end else begin
      m_aluResult <= x_aluResult;
      m_writeData <= x_writeData;
      m_writeReg  <= x_writeReg;
      m_WB        <= x_WB;
      m_M         <= x_M;
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed test-plan cases plus randomized
// instructions checked against an arithmetic reference model.
module tb_exec_stage;
  localparam int DW = 32;

  logic          clk, pc_rst;
  logic [1:0]    x_aluOp;
  logic [5:0]    x_funct;
  logic [4:0]    x_shamt;
  logic [DW-1:0] x_aluIn0, x_aluIn1, x_writeData;
  logic [4:0]    x_writeReg;
  logic [1:0]    x_WB;
  logic [2:0]    x_M;
  logic [3:0]    x_operation;
  logic [DW-1:0] x_aluResult;
  logic          x_zero;
  logic [DW-1:0] m_aluResult, m_writeData;
  logic [4:0]    m_writeReg;
  logic [1:0]    m_WB;
  logic [2:0]    m_M;

  int passed = 0;
  int total  = 0;

  exec_stage #(.DATA_W(DW)) dut (
    .clk(clk), .pc_rst(pc_rst),
    .x_aluOp(x_aluOp), .x_funct(x_funct), .x_shamt(x_shamt),
    .x_aluIn0(x_aluIn0), .x_aluIn1(x_aluIn1), .x_writeData(x_writeData),
    .x_writeReg(x_writeReg), .x_WB(x_WB), .x_M(x_M),
    .x_operation(x_operation), .x_aluResult(x_aluResult), .x_zero(x_zero),
    .m_aluResult(m_aluResult), .m_writeData(m_writeData), .m_writeReg(m_writeReg),
    .m_WB(m_WB), .m_M(m_M)
  );

  initial clk = 0;
  always #5 clk = ~clk;

`ifdef EXEC_SHIFT_EN
  localparam bit SHIFTS = 1'b1;
`else
  localparam bit SHIFTS = 1'b0;
`endif

  // Reference: instruction semantics straight from the ISA description
  function automatic void model(input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh,
                                input logic [DW-1:0] a, input logic [DW-1:0] b,
                                output logic [3:0] oper, output logic [DW-1:0] res);
    string name;
    longint sa, sb;
    if (op == 2'b01) name = "sub";
    else if (op != 2'b10) name = "add";
    else if (f == 6'd32) name = "add";
    else if (f == 6'd34) name = "sub";
    else if (f == 6'd36) name = "and";
    else if (f == 6'd37) name = "or";
    else if (f == 6'd39) name = "nor";
    else if (f == 6'd42) name = "slt";
    else if (SHIFTS && f == 6'd0) name = "sll";
    else if (SHIFTS && f == 6'd2) name = "srl";
    else name = "add";
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (name)
      "add": begin oper = 4'd2;  res = DW'((longint'(a) + longint'(b)) % (64'd1 << DW)); end
      "sub": begin oper = 4'd6;  res = DW'(longint'(a) - longint'(b) + (64'd1 << DW)); end
      "and": begin oper = 4'd0;  res = a & b; end
      "or":  begin oper = 4'd1;  res = a | b; end
      "nor": begin oper = 4'd12; res = ~(a | b); end
      "slt": begin oper = 4'd7;  res = (sa < sb) ? 1 : 0; end
      "sll": begin oper = 4'd3;  res = DW'(longint'(b) * (64'd1 << sh)); end
      default: begin oper = 4'd4; res = DW'(longint'(b) / (64'd1 << sh)); end
    endcase
  endfunction

  task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh,
                       input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] wd,
                       input logic [4:0] wr, input logic [1:0] wb, input logic [2:0] m);
    x_aluOp = op; x_funct = f; x_shamt = sh; x_aluIn0 = a; x_aluIn1 = b;
    x_writeData = wd; x_writeReg = wr; x_WB = wb; x_M = m;
  endtask

  task automatic test_reset;
    drive(2'b10, 6'd32, 5'd0, 32'd7, 32'd5, 32'hFFFF_FFFF, 5'd31, 2'b11, 3'b111);
    pc_rst = 0;
    #2;
    total++;
    if ({m_aluResult, m_writeData, m_writeReg, m_WB, m_M} !== '0)
      $display("FAIL reset_state: m=%h expected 0", {m_aluResult, m_writeData, m_writeReg, m_WB, m_M});
    else passed++;
    @(posedge clk); #1;
    total++;
    if ({m_aluResult, m_WB, m_M} !== '0)
      $display("FAIL reset_hold: m=%h expected 0", {m_aluResult, m_WB, m_M});
    else passed++;
    total++;
    if (x_aluResult !== 32'd12)
      $display("FAIL comb_during_reset: x_aluResult=%h expected 0000000c", x_aluResult);
    else passed++;
    pc_rst = 1;
  endtask

  task automatic test_directed;
    logic [3:0] eo; logic [DW-1:0] er;
    @(posedge clk); #1;
    drive(2'b10, 6'b100000, 5'd0, 32'd7, 32'd5, 32'd0, 5'd0, 2'b00, 3'b000);
    #1;
    total++;
    if (x_operation !== 4'b0010 || x_aluResult !== 32'd12 || x_zero !== 1'b0)
      $display("FAIL add_7_5: op=%b res=%h z=%b expected 0010/0000000c/0", x_operation, x_aluResult, x_zero);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (m_aluResult !== 32'd12) $display("FAIL add_latched: m_aluResult=%h expected 0000000c", m_aluResult);
    else passed++;
    drive(2'b01, 6'd0, 5'd0, 32'h1234, 32'h1234, 32'd0, 5'd0, 2'b00, 3'b000); #1;
    total++;
    if (x_operation !== 4'b0110 || x_aluResult !== 32'd0 || x_zero !== 1'b1)
      $display("FAIL beq_sub: op=%b res=%h z=%b expected 0110/00000000/1", x_operation, x_aluResult, x_zero);
    else passed++;
    drive(2'b00, 6'd0, 5'd0, 32'h100, 32'hFFFF_FFFC, 32'd0, 5'd0, 2'b00, 3'b000); #1;
    total++;
    if (x_aluResult !== 32'hFC) $display("FAIL mem_add_wrap: res=%h expected 000000fc", x_aluResult);
    else passed++;
    drive(2'b10, 6'b100100, 5'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 5'd0, 2'b00, 3'b000); #1;
    total++;
    if (x_aluResult !== 32'h00F0_00F0) $display("FAIL and: res=%h expected 00f000f0", x_aluResult);
    else passed++;
    x_funct = 6'b100101; #1;
    total++;
    if (x_aluResult !== 32'hFFF0_FFF0) $display("FAIL or: res=%h expected fff0fff0", x_aluResult);
    else passed++;
    x_funct = 6'b100111; #1;
    total++;
    if (x_aluResult !== 32'h000F_000F) $display("FAIL nor: res=%h expected 000f000f", x_aluResult);
    else passed++;
    drive(2'b10, 6'b101010, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 2'b00, 3'b000); #1;
    total++;
    if (x_aluResult !== 32'd1 || x_operation !== 4'b0111)
      $display("FAIL slt_neg: op=%b res=%h expected 0111/00000001", x_operation, x_aluResult);
    else passed++;
    x_aluIn0 = 32'd1; x_aluIn1 = 32'hFFFF_FFFF; #1;
    total++;
    if (x_aluResult !== 32'd0 || x_zero !== 1'b1)
      $display("FAIL slt_pos: res=%h z=%b expected 00000000/1", x_aluResult, x_zero);
    else passed++;
    // shift encodings: SLL/SRL with macro, plain ADD without
    drive(2'b10, 6'b000000, 5'd4, 32'd3, 32'd1, 32'd0, 5'd0, 2'b00, 3'b000); #1;
    model(2'b10, 6'b000000, 5'd4, 32'd3, 32'd1, eo, er);
    total++;
    if (x_aluResult !== er || x_operation !== eo)
      $display("FAIL shift_sll: op=%b res=%h expected %b/%h", x_operation, x_aluResult, eo, er);
    else passed++;
    drive(2'b10, 6'b000010, 5'd31, 32'd3, 32'h8000_0000, 32'd0, 5'd0, 2'b00, 3'b000); #1;
    model(2'b10, 6'b000010, 5'd31, 32'd3, 32'h8000_0000, eo, er);
    total++;
    if (x_aluResult !== er || x_operation !== eo)
      $display("FAIL shift_srl: op=%b res=%h expected %b/%h", x_operation, x_aluResult, eo, er);
    else passed++;
  endtask

  task automatic test_passthrough;
    @(posedge clk); #1;
    drive(2'b00, 6'd0, 5'd0, 32'd1, 32'd2, 32'hDEAD_BEEF, 5'd9, 2'b11, 3'b010);
    @(posedge clk); #1;
    total++;
    if (m_aluResult !== 32'd3 || m_writeData !== 32'hDEAD_BEEF || m_writeReg !== 5'd9 ||
        m_WB !== 2'b11 || m_M !== 3'b010)
      $display("FAIL passthrough: m=%h/%h/%0d/%b/%b expected 00000003/deadbeef/9/11/010",
               m_aluResult, m_writeData, m_writeReg, m_WB, m_M);
    else passed++;
    drive(2'b00, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 2'b00, 3'b000);
    #3;
    total++;
    if (m_writeData !== 32'hDEAD_BEEF || m_writeReg !== 5'd9 || m_WB !== 2'b11 || m_M !== 3'b010)
      $display("FAIL passthrough_hold: m=%h/%0d/%b/%b expected deadbeef/9/11/010",
               m_writeData, m_writeReg, m_WB, m_M);
    else passed++;
  endtask

  task automatic test_async_reset;
    @(posedge clk); #1;
    drive(2'b11, 6'd0, 5'd0, 32'd40, 32'd2, 32'h55, 5'd17, 2'b01, 3'b001);
    @(posedge clk); #3;
    total++;
    if (m_aluResult !== 32'd42 || m_writeReg !== 5'd17)
      $display("FAIL prereset_capture: m=%h/%0d expected 0000002a/17", m_aluResult, m_writeReg);
    else passed++;
    pc_rst = 0; #1;
    total++;
    if ({m_aluResult, m_writeData, m_writeReg, m_WB, m_M} !== '0)
      $display("FAIL async_clear: m=%h expected 0", {m_aluResult, m_writeData, m_writeReg, m_WB, m_M});
    else passed++;
    @(posedge clk); #1;
    total++;
    if ({m_aluResult, m_writeData, m_writeReg, m_WB, m_M} !== '0)
      $display("FAIL async_hold: m=%h expected 0", {m_aluResult, m_writeData, m_writeReg, m_WB, m_M});
    else passed++;
    #2 pc_rst = 1; #1;
    total++;
    if (m_WB !== 2'b00 || m_aluResult !== 32'd0)
      $display("FAIL release_no_capture: m_WB=%b res=%h expected 00/00000000", m_WB, m_aluResult);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (m_aluResult !== 32'd42 || m_WB !== 2'b01 || m_M !== 3'b001)
      $display("FAIL release_capture: m=%h/%b/%b expected 0000002a/01/001", m_aluResult, m_WB, m_M);
    else passed++;
  endtask

  task automatic test_random;
    logic [5:0] functs [8];
    logic [3:0] eo; logic [DW-1:0] er, a, b, wd;
    logic [1:0] op, wb; logic [5:0] f; logic [4:0] sh, wr; logic [2:0] m;
    int bad_c = 0, bad_r = 0;
    functs = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd0, 6'd2};
    for (int i = 0; i < 300; i++) begin
      op = 2'($urandom); sh = 5'($urandom); wr = 5'($urandom);
      wb = 2'($urandom); m = 3'($urandom); wd = $urandom;
      f = ($urandom_range(0, 4) == 0) ? 6'($urandom) : functs[$urandom_range(0, 7)];
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      @(posedge clk); #1;
      drive(op, f, sh, a, b, wd, wr, wb, m);
      model(op, f, sh, a, b, eo, er);
      #1;
      if (x_operation !== eo || x_aluResult !== er || x_zero !== (er == 0)) begin
        if (bad_c < 5)
          $display("FAIL rand_comb[%0d]: op=%b f=%b a=%h b=%h got %b/%h/%b expected %b/%h/%b",
                   i, op, f, a, b, x_operation, x_aluResult, x_zero, eo, er, (er == 0));
        bad_c++;
      end
      @(posedge clk); #1;
      if (m_aluResult !== er || m_writeData !== wd || m_writeReg !== wr || m_WB !== wb || m_M !== m) begin
        if (bad_r < 5)
          $display("FAIL rand_reg[%0d]: got %h/%h/%0d/%b/%b expected %h/%h/%0d/%b/%b", i,
                   m_aluResult, m_writeData, m_writeReg, m_WB, m_M, er, wd, wr, wb, m);
        bad_r++;
      end
    end
    total++;
    if (bad_c != 0) $display("FAIL rand_comb_total: %0d bad cycles expected 0", bad_c);
    else passed++;
    total++;
    if (bad_r != 0) $display("FAIL rand_reg_total: %0d bad cycles expected 0", bad_r);
    else passed++;
  endtask

  initial begin
    pc_rst = 0;
    drive(2'b00, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 2'b00, 3'b000);
    test_reset;
    test_directed;
    test_passthrough;
    test_async_reset;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
